// File: rtl/sample_coder_pack.sv
// Multi-channel sample coder: encodes NCH channel bits per accepted sample into 2-bit
// symbols (raw or edge), packs SPW samples per word and queues words in an output FIFO.
module sample_coder_pack #(
   parameter int NCH        = 4,
   parameter int WORD_W     = 32,
   parameter int FIFO_DEPTH = 4,
   localparam int SYMW      = 2 * NCH,
   localparam int SPW       = WORD_W / SYMW,
   localparam int NSW       = $clog2(SPW) + 1,
   localparam int PW        = $clog2(FIFO_DEPTH)
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              enable,
   input  logic              mode,
   input  logic              sample_stb,
   input  logic [NCH-1:0]    data,
   input  logic              flush,
   output logic [WORD_W-1:0] out_data,
   output logic [NSW-1:0]    out_nsamp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   input  logic              clr_overflow
);

   logic              accept;
   logic              eff_mode;
   logic              push;
   logic              pop;
   logic              full;
   logic              fifo_wr;
   logic [SYMW-1:0]   sym;
   logic [WORD_W-1:0] word_d;
   logic [NSW-1:0]    nsamp_d;
   logic [PW:0]       fill_d;
   logic              overflow_d;

   logic [WORD_W-1:0] acc_q;
   logic [NSW-1:0]    cnt_q;
   logic              mode_q;
   logic              primed_q;
   logic [NCH-1:0]    prev_q;
   logic [WORD_W-1:0] mem_word_q  [FIFO_DEPTH];
   logic [NSW-1:0]    mem_nsamp_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [PW:0]       fill_q;
   logic              overflow_q;

   // The first sample of a word is coded with the live mode input, the rest with the latched one.
   always_comb begin
      accept   = sample_stb & enable;
      eff_mode = (cnt_q == '0) ? mode : mode_q;
      sym      = '0;
      for (int i = 0; i < NCH; i++) begin
         sym[2*i]   = data[i];
         sym[2*i+1] = eff_mode & primed_q & (data[i] ^ prev_q[i]);
      end
      word_d  = acc_q;
      if (accept) begin
         word_d = acc_q | (WORD_W'(sym) << (int'(cnt_q) * SYMW));
      end
      nsamp_d = cnt_q + {{(NSW-1){1'b0}}, accept};
      push    = (accept && (cnt_q == NSW'(SPW - 1))) || (flush && (nsamp_d != '0));
   end

   always_comb begin
      full       = (fill_q == (PW+1)'(FIFO_DEPTH));
      pop        = out_valid & out_ready;
      fifo_wr    = push & (~full | pop);
      fill_d     = fill_q;
      if (fifo_wr && !pop) begin
         fill_d = fill_q + (PW+1)'(1);
      end else if (!fifo_wr && pop) begin
         fill_d = fill_q - (PW+1)'(1);
      end
      overflow_d = overflow_q;
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         primed_q   <= 1'b0;
         prev_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept) begin
            prev_q   <= data;
            primed_q <= 1'b1;
         end else if (!enable) begin
            primed_q <= 1'b0;
         end
         if (accept && (cnt_q == '0)) begin
            mode_q <= mode;
         end
         // A completed word always restarts the accumulator, even when the FIFO drops it.
         if (push) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else if (accept) begin
            acc_q <= word_d;
            cnt_q <= nsamp_d;
         end
         if (fifo_wr) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         fill_q     <= fill_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (fifo_wr) begin
         mem_word_q[wr_ptr_q]  <= word_d;
         mem_nsamp_q[wr_ptr_q] <= nsamp_d;
      end
   end

   assign out_valid = (fill_q != '0);
   assign out_data  = out_valid ? mem_word_q[rd_ptr_q] : '0;
   assign out_nsamp = out_valid ? mem_nsamp_q[rd_ptr_q] : '0;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_sample_coder_pack.sv
// Bench for sample_coder_pack: directed scenarios plus randomized traffic against a
// sample-list reference model of the coder and its output queue.
module tb_sample_coder_pack;

   localparam int NCH   = 4;
   localparam int WW    = 32;
   localparam int SPW   = 4;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          mode;
   logic          sample_stb;
   logic [3:0]    data;
   logic          flush;
   logic [WW-1:0] out_data;
   logic [2:0]    out_nsamp;
   logic          out_valid;
   logic          out_ready;
   logic          overflow;
   logic          clr_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pending symbols of the open word, and the expected queue {nsamp, word}.
   logic [7:0]  m_syms[$];
   logic [34:0] exp_q[$];
   logic [3:0]  m_prev;
   bit          m_primed;
   bit          m_wmode;
   bit          m_ovf;

   sample_coder_pack #(.NCH(NCH), .WORD_W(WW), .FIFO_DEPTH(DEPTH)) dut (
      .sys_clk      (clk),
      .sys_rst_n    (rst_n),
      .enable       (enable),
      .mode         (mode),
      .sample_stb   (sample_stb),
      .data         (data),
      .flush        (flush),
      .out_data     (out_data),
      .out_nsamp    (out_nsamp),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_syms.delete();
      exp_q.delete();
      m_prev   = '0;
      m_primed = 1'b0;
      m_wmode  = 1'b0;
      m_ovf    = 1'b0;
   endfunction

   function automatic void model_cycle(input bit stb, input bit fl);
      bit         acc;
      bit         pop;
      bit         done;
      logic [7:0] s;
      logic [31:0] w;
      int         n;
      acc  = stb && enable;
      pop  = out_ready && (exp_q.size() != 0);
      done = 1'b0;
      w    = '0;
      n    = 0;
      if (acc) begin
         if (m_syms.size() == 0) m_wmode = mode;
         s = '0;
         for (int i = 0; i < NCH; i++) begin
            s[2*i]   = data[i];
            s[2*i+1] = m_wmode && m_primed && (data[i] != m_prev[i]);
         end
         m_syms.push_back(s);
         m_prev   = data;
         m_primed = 1'b1;
      end else if (!enable) begin
         m_primed = 1'b0;
      end
      if ((acc && m_syms.size() == SPW) || (fl && m_syms.size() != 0)) begin
         foreach (m_syms[k]) w = w | (32'(m_syms[k]) << (8 * k));
         n = m_syms.size();
         m_syms.delete();
         done = 1'b1;
      end
      if (pop) void'(exp_q.pop_front());
      if (done && exp_q.size() >= DEPTH) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (done && exp_q.size() < DEPTH) exp_q.push_back({3'(n), w});
   endfunction

   task automatic step(input bit stb, input logic [3:0] d, input bit fl);
      sample_stb = stb;
      data       = d;
      flush      = fl;
      model_cycle(stb, fl);
      @(posedge clk);
      #1;
      sample_stb = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 0; mode = 0; sample_stb = 0; data = '0;
      flush = 0; out_ready = 0; clr_overflow = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
      n_checks++; if (out_nsamp !== 3'd0) begin n_fail++; $display("FAIL reset_nsamp: got %0d expected 0", out_nsamp); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      rst_n = 1'b1;
      step(0, 4'h0, 0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_raw();
      enable = 1; mode = 0; out_ready = 0;
      step(1, 4'hA, 0);
      step(1, 4'h5, 0);
      step(1, 4'hF, 0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_early_valid: got %b expected 0", out_valid); end
      step(1, 4'h0, 0);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL raw_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_data !== 32'h00551144) begin n_fail++; $display("FAIL raw_data: got %h expected 00551144", out_data); end
      n_checks++; if (out_nsamp !== 3'd4) begin n_fail++; $display("FAIL raw_nsamp: got %0d expected 4", out_nsamp); end
      step(0, 4'h0, 0);
      n_checks++; if (out_data !== 32'h00551144) begin n_fail++; $display("FAIL raw_hold: got %h expected 00551144", out_data); end
      out_ready = 1;
      step(0, 4'h0, 0);
      out_ready = 0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_pop: got %b expected 0", out_valid); end
   endtask

   task automatic test_edge();
      enable = 0;
      step(0, 4'h0, 0);
      enable = 1; mode = 1;
      step(1, 4'h0, 0);
      step(1, 4'h1, 0);
      step(1, 4'h1, 0);
      step(1, 4'h0, 0);
      n_checks++; if (out_data !== 32'h02010300) begin n_fail++; $display("FAIL edge_data: got %h expected 02010300", out_data); end
      n_checks++; if (out_nsamp !== 3'd4) begin n_fail++; $display("FAIL edge_nsamp: got %0d expected 4", out_nsamp); end
      out_ready = 1;
      step(0, 4'h0, 0);
      out_ready = 0;
   endtask

   task automatic test_flush();
      mode = 0;
      step(1, 4'hF, 0);
      step(1, 4'hF, 0);
      step(0, 4'h0, 1);
      n_checks++; if (out_data !== 32'h00005555) begin n_fail++; $display("FAIL flush_data: got %h expected 00005555", out_data); end
      n_checks++; if (out_nsamp !== 3'd2) begin n_fail++; $display("FAIL flush_nsamp: got %0d expected 2", out_nsamp); end
      step(1, 4'hF, 0);
      step(1, 4'hF, 0);
      step(1, 4'hF, 1);
      step(0, 4'h0, 1);
      out_ready = 1;
      step(0, 4'h0, 0);
      out_ready = 0;
      n_checks++; if (out_data !== 32'h00555555) begin n_fail++; $display("FAIL flush_coinc_data: got %h expected 00555555", out_data); end
      n_checks++; if (out_nsamp !== 3'd3) begin n_fail++; $display("FAIL flush_coinc_nsamp: got %0d expected 3", out_nsamp); end
      out_ready = 1;
      step(0, 4'h0, 0);
      out_ready = 0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_noop: got %b expected 0", out_valid); end
   endtask

   task automatic test_overflow();
      logic [31:0] words[4];
      out_ready = 0; mode = 0;
      for (int k = 0; k < 5 * SPW; k++) begin
         step(1, 4'($urandom_range(0, 15)), 0);
         if (k == 4 * SPW - 1) begin
            foreach (exp_q[j]) words[j] = exp_q[j][31:0];
            n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_4: got %b expected 0", overflow); end
         end
      end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_at_5: got %b expected 1", overflow); end
      for (int j = 0; j < DEPTH; j++) begin
         n_checks++; if (out_data !== words[j]) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h expected %h", j, out_data, words[j]); end
         out_ready = 1;
         step(0, 4'h0, 0);
         out_ready = 0;
      end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", out_valid); end
      clr_overflow = 1;
      step(0, 4'h0, 0);
      clr_overflow = 0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
   endtask

   task automatic test_full_pushpop();
      out_ready = 0; mode = 0;
      for (int k = 0; k < 4 * SPW + 3; k++) step(1, 4'($urandom_range(0, 15)), 0);
      out_ready = 1;
      step(1, 4'($urandom_range(0, 15)), 0);
      out_ready = 0;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf: got %b expected 0", overflow); end
      n_checks++; if (out_data !== exp_q[0][31:0]) begin n_fail++; $display("FAIL pushpop_head: got %h expected %h", out_data, exp_q[0][31:0]); end
      // Still full: another completion with clear asserted must set overflow anyway.
      for (int k = 0; k < SPW - 1; k++) step(1, 4'($urandom_range(0, 15)), 0);
      clr_overflow = 1;
      step(1, 4'($urandom_range(0, 15)), 0);
      clr_overflow = 0;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b expected 1", overflow); end
      for (int j = 0; j < DEPTH; j++) begin
         n_checks++; if (out_data !== exp_q[0][31:0]) begin n_fail++; $display("FAIL pushpop_drain_%0d: got %h expected %h", j, out_data, exp_q[0][31:0]); end
         out_ready = 1;
         step(0, 4'h0, 0);
         out_ready = 0;
      end
      clr_overflow = 1;
      step(0, 4'h0, 0);
      clr_overflow = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         enable       = ($urandom_range(0, 9) != 0);
         mode         = 1'($urandom_range(0, 1));
         out_ready    = ($urandom_range(0, 2) == 0);
         clr_overflow = ($urandom_range(0, 15) == 0);
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
         clr_overflow = 0;
         n_checks++; if (out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, out_valid, exp_q.size() != 0); end
         n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d: got %b expected %b", c, overflow, m_ovf); end
         if (exp_q.size() != 0) begin
            n_checks++; if (out_data !== exp_q[0][31:0]) begin n_fail++; $display("FAIL rnd_data c%0d: got %h expected %h", c, out_data, exp_q[0][31:0]); end
            n_checks++; if (out_nsamp !== exp_q[0][34:32]) begin n_fail++; $display("FAIL rnd_nsamp c%0d: got %0d expected %0d", c, out_nsamp, exp_q[0][34:32]); end
         end
      end
      out_ready = 0;
   endtask

   task automatic test_async_reset();
      enable = 1; mode = 0; out_ready = 0;
      for (int k = 0; k < SPW + 2; k++) step(1, 4'($urandom_range(0, 15)), 0);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL arst_data: got %h expected 00000000", out_data); end
      n_checks++; if (out_nsamp !== 3'd0) begin n_fail++; $display("FAIL arst_nsamp: got %0d expected 0", out_nsamp); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_overflow: got %b expected 0", overflow); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 4'h1, 0);
      step(1, 4'h2, 0);
      step(1, 4'h4, 0);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_partial: got %b expected 0", out_valid); end
      step(1, 4'h8, 0);
      n_checks++; if (out_data !== 32'h40100401) begin n_fail++; $display("FAIL arst_word: got %h expected 40100401", out_data); end
      n_checks++; if (out_nsamp !== 3'd4) begin n_fail++; $display("FAIL arst_nsamp4: got %0d expected 4", out_nsamp); end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_edge();
      test_flush();
      test_overflow();
      test_full_pushpop();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
